// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES inverse-cipher sequencer and its neighbours.
// Blocks are big-endian by byte: byte 0 occupies [127:120].
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ctrl_state_e;

    typedef logic [127:0] block_t;

    function automatic logic [7:0] get_byte(input block_t b, input int i);
        return b[127 - 8*i -: 8];
    endfunction

    function automatic block_t set_byte(input block_t b, input int i, input logic [7:0] v);
        block_t r;
        r = b;
        r[127 - 8*i -: 8] = v;
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the state register and round counter,
// steering an external combinational inverse-round datapath one round per clock.
//   state | meaning
//   IDLE  | waiting for ciphertext (needs key_ready)
//   ROUND | one inverse round per clock, rk_idx = cnt counting down to 0
//   DONE  | plaintext held on out_data until out_ready
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  block_t        in_data,
    output logic [CW-1:0] rk_idx,
    input  block_t        rk_data,
    output block_t        dp_state,
    output logic          dp_last,
    input  block_t        dp_result,
    output logic          out_valid,
    input  logic          out_ready,
    output block_t        out_data,
    output logic          busy
);

    if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
        $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14");
    end
    if ((1 << CW) <= NR) begin : g_bad_cw
        $error("aes_inv_cipher_ctrl: CW too narrow to hold NR");
    end

    ctrl_state_e   state_q, state_d;
    block_t        blk_q, blk_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    assign in_ready  = ~rst & key_ready &
                       ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign rk_idx    = (state_q == ROUND) ? cnt_q : CW'(NR);
    assign dp_last   = (state_q == ROUND) && (cnt_q == '0);
    assign dp_state  = blk_q;
    assign out_data  = blk_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: ;
            ROUND: begin
                blk_d = dp_result;
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Accept overrides: in DONE this consumes the output and loads the next block together.
        if (accept) begin
            blk_d   = in_data ^ rk_data;
            cnt_d   = CW'(NR - 1);
            state_d = ROUND;
        end
    end

endmodule
